fp_seq: RTL and testbench

Floating-point/AWP sequencer: the control-side counterpart of the F-PM microoperation unit. It steps through the F-state sequence (F2, F4, F5, F6, F7, F8, F9, F10, F13) and issues the active-low state lines plus the `strob_fp` / `strob2_fp` strobes that F-PM consumes. It advances or loops on the status F-PM returns: `fic` (counter expired), `g`, `nz` and `di`. It sits between the instruction control unit, which issues `start` for any `puf` instruction, and F-PM.

---
 rtl/fp_seq_if.sv | 23 ++
 rtl/fp_seq.sv | 164 ++++++++++++++++
 tb/tb_fp_seq.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_seq_if.sv
// Signal bundle between the instruction control unit / F-PM and the F-state sequencer.
// The sequencer takes the slave view; the requester and F-PM side take the master view.
interface fp_seq_if;
  logic start;
  logic ff, af_sf, ad_sd, mw_mf, dw_df;
  logic fic, g, nz, di;
  logic f2_, f4_, f5_, f6_, f7_, f8_, f10_;
  logic f9, f13;
  logic strob_fp, strob2_fp;
  logic busy, done, err;

  modport master (
    output start, ff, af_sf, ad_sd, mw_mf, dw_df, fic, g, nz, di,
    input  f2_, f4_, f5_, f6_, f7_, f8_, f10_, f9, f13,
    input  strob_fp, strob2_fp, busy, done, err
  );

  modport slave (
    input  start, ff, af_sf, ad_sd, mw_mf, dw_df, fic, g, nz, di,
    output f2_, f4_, f5_, f6_, f7_, f8_, f10_, f9, f13,
    output strob_fp, strob2_fp, busy, done, err
  );
endinterface

// File: rtl/fp_seq.sv
// F-state sequencer for the F-PM microoperation unit: walks F2..F13 in three strobed phases.
// state | meaning: IDLE wait start; F2..F13 F-PM step (P0 settle, P1 strob_fp, P2 strob2_fp); END done pulse
module fp_seq #(
  parameter int PHASE_CYCLES = 1,
  parameter int LOOP_LIMIT   = 63
) (
  input logic     __clk,
  input logic     _0_f,
  fp_seq_if.slave io_fp
);
  typedef enum logic [3:0] {
    S_IDLE, S_F2, S_F4, S_F5, S_F6, S_F7, S_F8, S_F9, S_F10, S_F13, S_END
  } state_t;

  localparam logic [3:0] LP_CNT_LAST = 4'(PHASE_CYCLES - 1);
  localparam logic [5:0] LP_LIMIT    = 6'(LOOP_LIMIT);

  state_t     r_state, w_state_nxt, w_route;
  logic [1:0] r_phase, w_phase_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [5:0] r_pass, w_pass_nxt;
  logic       r_ff, r_af, r_mw, r_dw;
  logic       w_accept, w_abort, w_loop, w_busy_nxt;

  logic r_f2_, r_f4_, r_f5_, r_f6_, r_f7_, r_f8_, r_f10_, r_f9, r_f13;
  logic r_strob, r_strob2, r_busy, r_done, r_err;

  always_comb begin
    w_route = S_END;
    w_loop  = 1'b0;
    case (r_state)
      S_F2:  w_route = S_F4;
      S_F4:  w_route = r_af ? S_F5 : S_F6;
      S_F5:  w_route = io_fp.g ? S_F9 : S_F8;
      S_F8: begin
        w_route = io_fp.fic ? S_F6 : S_F8;
        w_loop  = !io_fp.fic;
      end
      S_F6:  w_route = S_F7;
      S_F7: begin
        w_loop  = (r_mw | r_dw) & !io_fp.fic;
        w_route = w_loop ? S_F6 : S_F9;
      end
      S_F9:  w_route = r_ff ? S_F10 : S_END;
      S_F10: begin
        w_loop  = io_fp.nz & !io_fp.fic;
        w_route = w_loop ? S_F10 : S_F13;
      end
      default: w_route = S_END;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_cnt;
    w_pass_nxt  = r_pass;
    w_accept    = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE, S_END: begin
        w_state_nxt = S_IDLE;
        w_phase_nxt = 2'd0;
        w_cnt_nxt   = LP_CNT_LAST;
        if (io_fp.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_F2;
          w_pass_nxt  = '0;
        end
      end
      default: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_cnt_nxt = LP_CNT_LAST;
          if (r_phase != 2'd2) begin
            w_phase_nxt = r_phase + 2'd1;
          end else begin
            w_phase_nxt = 2'd0;
            // interrupt and hang both abort at the state boundary, never mid-strobe
            if (io_fp.di || (r_pass == LP_LIMIT)) begin
              w_state_nxt = S_END;
              w_abort     = 1'b1;
            end else begin
              w_state_nxt = w_route;
              if (w_loop) w_pass_nxt = r_pass + 6'd1;
            end
          end
        end
      end
    endcase
  end

  assign w_busy_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_END);

  always_ff @(posedge __clk) begin
    if (_0_f) begin
      r_state  <= S_IDLE;
      r_phase  <= 2'd0;
      r_cnt    <= LP_CNT_LAST;
      r_pass   <= '0;
      r_ff     <= 1'b0;
      r_af     <= 1'b0;
      r_mw     <= 1'b0;
      r_dw     <= 1'b0;
      r_f2_    <= 1'b1;
      r_f4_    <= 1'b1;
      r_f5_    <= 1'b1;
      r_f6_    <= 1'b1;
      r_f7_    <= 1'b1;
      r_f8_    <= 1'b1;
      r_f10_   <= 1'b1;
      r_f9     <= 1'b0;
      r_f13    <= 1'b0;
      r_strob  <= 1'b0;
      r_strob2 <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pass  <= w_pass_nxt;
      if (w_accept) begin
        r_ff <= io_fp.ff;
        r_af <= io_fp.af_sf;
        r_mw <= io_fp.mw_mf;
        r_dw <= io_fp.dw_df;
      end
      // outputs follow the next state so they change together with it
      r_f2_    <= (w_state_nxt != S_F2);
      r_f4_    <= (w_state_nxt != S_F4);
      r_f5_    <= (w_state_nxt != S_F5);
      r_f6_    <= (w_state_nxt != S_F6);
      r_f7_    <= (w_state_nxt != S_F7);
      r_f8_    <= (w_state_nxt != S_F8);
      r_f10_   <= (w_state_nxt != S_F10);
      r_f9     <= (w_state_nxt == S_F9);
      r_f13    <= (w_state_nxt == S_F13);
      r_strob  <= w_busy_nxt && (w_phase_nxt == 2'd1);
      r_strob2 <= w_busy_nxt && (w_phase_nxt == 2'd2);
      r_busy   <= w_busy_nxt;
      r_done   <= (w_state_nxt == S_END);
      if (w_accept)     r_err <= 1'b0;
      else if (w_abort) r_err <= 1'b1;
    end
  end

  assign io_fp.f2_       = r_f2_;
  assign io_fp.f4_       = r_f4_;
  assign io_fp.f5_       = r_f5_;
  assign io_fp.f6_       = r_f6_;
  assign io_fp.f7_       = r_f7_;
  assign io_fp.f8_       = r_f8_;
  assign io_fp.f10_      = r_f10_;
  assign io_fp.f9        = r_f9;
  assign io_fp.f13       = r_f13;
  assign io_fp.strob_fp  = r_strob;
  assign io_fp.strob2_fp = r_strob2;
  assign io_fp.busy      = r_busy;
  assign io_fp.done      = r_done;
  assign io_fp.err       = r_err;
endmodule

// File: tb/tb_fp_seq.sv
// Self-checking bench for fp_seq: directed F-state sequences plus randomized runs vs. a visit-level model.
module tb_fp_seq;
  // visit codes used by the bench (independent of the design's encoding)
  localparam int C_F2 = 1, C_F4 = 2, C_F5 = 3, C_F6 = 4, C_F7 = 5, C_F8 = 6, C_F9 = 7, C_F10 = 8, C_F13 = 9;
  localparam int C_END = 0;
  localparam int LIMIT = 63;
  localparam logic [8:0]  IDLE_L  = 9'b111111100;
  localparam logic [13:0] RST_VEC = {IDLE_L, 5'b00000};

  typedef struct packed {
    logic ff, af, ad, mw, dw, g, nz;
    logic [7:0] fic_rise;
    logic [7:0] di_vis;
    logic [4:0] n;
    logic [15:0][3:0] seq;
    logic err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_seq_if if1();
  fp_seq_if if4();

  fp_seq #(.PHASE_CYCLES(1), .LOOP_LIMIT(LIMIT)) u_dut1 (.__clk(clk), ._0_f(rst), .io_fp(if1));
  fp_seq #(.PHASE_CYCLES(4), .LOOP_LIMIT(LIMIT)) u_dut4 (.__clk(clk), ._0_f(rst), .io_fp(if4));

  int n_chk = 0;
  int n_fail = 0;

  int   vis_state [256];
  bit   vis_fic [256], vis_g [256], vis_nz [256], vis_di [256];
  int   n_vis;
  logic exp_err;
  logic [4:0] p_ops;   // {ff, af_sf, ad_sd, mw_mf, dw_df}

  vec_t vt [7];

  function automatic vec_t mk(input logic [6:0] fl, input int rise, input int dv, input int n,
                              input logic [63:0] seq, input logic err);
    vec_t v;
    {v.ff, v.af, v.ad, v.mw, v.dw, v.g, v.nz} = fl;
    v.fic_rise = 8'(rise);
    v.di_vis   = 8'(dv);
    v.n        = 5'(n);
    v.seq      = seq;
    v.err      = err;
    return v;
  endfunction

  function automatic logic [8:0] exp_lines(input int c);
    logic [8:0] v;
    v = IDLE_L;
    case (c)
      C_F2:  v[8] = 1'b0;
      C_F4:  v[7] = 1'b0;
      C_F5:  v[6] = 1'b0;
      C_F6:  v[5] = 1'b0;
      C_F7:  v[4] = 1'b0;
      C_F8:  v[3] = 1'b0;
      C_F10: v[2] = 1'b0;
      C_F9:  v[1] = 1'b1;
      C_F13: v[0] = 1'b1;
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic [13:0] act(input int sel);
    if (sel == 0)
      return {if1.f2_, if1.f4_, if1.f5_, if1.f6_, if1.f7_, if1.f8_, if1.f10_, if1.f9, if1.f13,
              if1.strob_fp, if1.strob2_fp, if1.busy, if1.done, if1.err};
    return {if4.f2_, if4.f4_, if4.f5_, if4.f6_, if4.f7_, if4.f8_, if4.f10_, if4.f9, if4.f13,
            if4.strob_fp, if4.strob2_fp, if4.busy, if4.done, if4.err};
  endfunction

  task automatic check(input string nm, input logic [13:0] a, input logic [13:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (lines|strob|strob2|busy|done|err)", nm, a, e);
    end
  endtask

  task automatic set_in(input int sel, input logic st, input logic [4:0] ops, input logic [3:0] stat);
    if (sel == 0) begin
      if1.start = st;
      {if1.ff, if1.af_sf, if1.ad_sd, if1.mw_mf, if1.dw_df} = ops;
      {if1.fic, if1.g, if1.nz, if1.di} = stat;
    end else begin
      if4.start = st;
      {if4.ff, if4.af_sf, if4.ad_sd, if4.mw_mf, if4.dw_df} = ops;
      {if4.fic, if4.g, if4.nz, if4.di} = stat;
    end
  endtask

  task automatic load_vec(input vec_t v);
    p_ops   = {v.ff, v.af, v.ad, v.mw, v.dw};
    n_vis   = int'(v.n);
    exp_err = v.err;
    for (int k = 0; k < n_vis; k++) begin
      vis_state[k] = int'(v.seq[15-k]);
      vis_fic[k]   = (k >= int'(v.fic_rise));
      vis_g[k]     = v.g;
      vis_nz[k]    = v.nz;
      vis_di[k]    = (k == int'(v.di_vis));
    end
  endtask

  // Visit-level reference: decides each F-state's successor from the operation rules.
  // mode 0: random op class and status; mode 1: multiply with fic stuck low (hang).
  task automatic gen_model(input int mode);
    int  s, nxt, passes;
    bit  fic, g, nz, di, lp, fin;
    if (mode == 0) p_ops = 5'($urandom);
    else           p_ops = 5'b00010;
    s = C_F2; passes = 0; n_vis = 0; exp_err = 1'b0; fin = 0;
    while (!fin) begin
      if (mode == 0) begin
        fic = ($urandom_range(0, 2) != 0);
        g   = ($urandom_range(0, 3) == 0);
        nz  = $urandom_range(0, 1) != 0;
        di  = ($urandom_range(0, 23) == 0);
      end else begin
        fic = 0; g = 0; nz = 1; di = 0;
      end
      vis_state[n_vis] = s; vis_fic[n_vis] = fic; vis_g[n_vis] = g;
      vis_nz[n_vis] = nz; vis_di[n_vis] = di;
      n_vis++;
      if (di || passes == LIMIT) begin
        exp_err = 1'b1;
        fin = 1;
      end else begin
        lp = 0;
        nxt = C_END;
        case (s)
          C_F2:  nxt = C_F4;
          C_F4:  nxt = p_ops[3] ? C_F5 : C_F6;
          C_F5:  nxt = g ? C_F9 : C_F8;
          C_F8:  begin lp = !fic; nxt = fic ? C_F6 : C_F8; end
          C_F6:  nxt = C_F7;
          C_F7:  begin lp = (p_ops[1] || p_ops[0]) && !fic; nxt = lp ? C_F6 : C_F9; end
          C_F9:  nxt = p_ops[4] ? C_F10 : C_END;
          C_F10: begin lp = nz && !fic; nxt = lp ? C_F10 : C_F13; end
          default: nxt = C_END;
        endcase
        if (lp) passes++;
        if (nxt == C_END) fin = 1;
        s = nxt;
      end
    end
  endtask

  // Drives one operation cycle by cycle and checks every output in every cycle.
  task automatic run_plan(input int sel, input int pc, input int rst_at,
                          input bit chain_out, input bit chain_in);
    int tot, k, pos;
    logic [13:0] ev;
    logic [3:0]  stat;
    logic        st;
    bit          fin;
    tot = n_vis * 3 * pc;
    fin = 0;
    k = 0;
    if (!chain_in) begin
      @(negedge clk);
      set_in(sel, 1'b1, p_ops, 4'b0000);
    end
    for (int t = 1; t <= tot + 2 && !fin; t++) begin
      @(negedge clk);
      if (rst_at != 0 && t == rst_at + 1) begin
        ev = RST_VEC;
      end else if (t <= tot) begin
        k   = (t - 1) / (3 * pc);
        pos = (t - 1) % (3 * pc);
        ev  = {exp_lines(vis_state[k]), (pos >= pc && pos < 2 * pc), (pos >= 2 * pc), 3'b100};
      end else if (t == tot + 1) begin
        ev = {IDLE_L, 2'b00, 2'b01, exp_err};
      end else begin
        ev = {IDLE_L, 4'b0000, exp_err};
      end
      check($sformatf("dut%0d cycle %0d visit %0d", (sel == 0) ? 1 : 4, t, k), act(sel), ev);
      if (rst_at != 0 && t == rst_at + 1) begin
        rst = 1'b0;
        set_in(sel, 1'b0, 5'b0, 4'b0);
        fin = 1;
      end else if (t == tot + 1 && chain_out) begin
        set_in(sel, 1'b1, p_ops, 4'b0000);
        fin = 1;
      end else begin
        if (rst_at != 0 && t == rst_at) rst = 1'b1;
        st   = (t <= tot) && ($urandom_range(0, 7) == 0);
        stat = (t <= tot) ? {vis_fic[k], vis_g[k], vis_nz[k], vis_di[k]} : 4'b0000;
        set_in(sel, st, 5'($urandom), stat);
      end
    end
  endtask

  initial begin
    //            ff af ad mw dw g nz   rise  di   n   visit sequence              err
    vt[0] = mk(7'b0_0_0_1_0_0_0,   0, 255,  5, 64'h1245_7000_0000_0000, 1'b0); // fixed point
    vt[1] = mk(7'b1_1_0_0_0_0_0,   5, 255, 11, 64'h1236_6645_7890_0000, 1'b0); // AF, 3 F8 passes
    vt[2] = mk(7'b1_1_0_0_0_1_0,   0, 255,  6, 64'h1237_8900_0000_0000, 1'b0); // AF, g skips F8
    vt[3] = mk(7'b0_0_0_0_1_0_0, 255,   3,  4, 64'h1245_0000_0000_0000, 1'b1); // divide, di in F7
    vt[4] = mk(7'b1_0_0_0_0_0_1,   7, 255,  9, 64'h1245_7888_9000_0000, 1'b0); // F10 normalise loop
    vt[5] = mk(7'b1_1_0_0_0_0_0, 255,   4,  5, 64'h1236_6000_0000_0000, 1'b1); // di in 2nd F8
    vt[6] = mk(7'b0_0_0_0_1_0_0,   5, 255,  7, 64'h1245_4570_0000_0000, 1'b0); // divide, one F6/F7 loop

    set_in(0, 1'b0, 5'b0, 4'b0);
    set_in(1, 1'b0, 5'b0, 4'b0);
    repeat (2) @(negedge clk);
    check("reset dut1", act(0), RST_VEC);
    check("reset dut4", act(1), RST_VEC);
    rst = 1'b0;
    @(negedge clk);
    check("idle dut1", act(0), RST_VEC);
    check("idle dut4", act(1), RST_VEC);

    for (int i = 0; i < 7; i++) begin
      load_vec(vt[i]);
      run_plan(0, 1, 0, 1'b0, 1'b0);
    end

    // four-cycle phases
    load_vec(vt[0]);
    run_plan(1, 4, 0, 1'b0, 1'b0);
    load_vec(vt[1]);
    run_plan(1, 4, 0, 1'b0, 1'b0);

    // hang abort on a multiply whose counter never expires
    gen_model(1);
    run_plan(0, 1, 0, 1'b0, 1'b0);

    // reset during F8 P1, then a clean run
    load_vec(vt[1]);
    run_plan(0, 1, 11, 1'b0, 1'b0);
    load_vec(vt[0]);
    run_plan(0, 1, 0, 1'b0, 1'b0);

    // reset and start together
    @(negedge clk);
    rst = 1'b1;
    set_in(0, 1'b1, 5'b10010, 4'b0000);
    @(negedge clk);
    check("reset beats start", act(0), RST_VEC);
    rst = 1'b0;
    set_in(0, 1'b0, 5'b0, 4'b0);

    // start accepted in the END cycle, after an aborted run
    load_vec(vt[3]);
    run_plan(0, 1, 0, 1'b1, 1'b0);
    load_vec(vt[0]);
    run_plan(0, 1, 0, 1'b0, 1'b1);

    for (int r = 0; r < 30; r++) begin
      gen_model(0);
      run_plan(0, 1, 0, 1'b0, 1'b0);
    end
    for (int r = 0; r < 4; r++) begin
      gen_model(0);
      run_plan(1, 4, 0, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
